// File: rtl/sync_fifo_ctrl_if.sv
// Handshake bundle between a producer/consumer pair and sync_fifo_ctrl.
interface sync_fifo_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] wdata;
  logic             wen;
  logic             full;
  logic             almost_full;
  logic             ren;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             empty;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
  logic             err_clr;

  // Producer/consumer side drives requests, observes status.
  modport master (
    output wdata, wen, ren, err_clr,
    input  full, almost_full, rdata, rvalid, empty, almost_empty,
           count, overflow, underflow
  );

  // FIFO side.
  modport slave (
    input  wdata, wen, ren, err_clr,
    output full, almost_full, rdata, rvalid, empty, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and selectable show-ahead or registered read.
module sync_fifo_ctrl #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned AFULL_THRESH  = DEPTH - 2,
  parameter int unsigned AEMPTY_THRESH = 1,
  parameter int unsigned FWFT          = 0
) (
  input logic            clk,
  input logic            rst,
  sync_fifo_ctrl_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  // Reject illegal configurations at elaboration.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("sync_fifo_ctrl: DEPTH must be a power of 2 and >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_chk_afull
    $error("sync_fifo_ctrl: AFULL_THRESH must be in 1..DEPTH");
  end
  if (AEMPTY_THRESH > DEPTH - 1) begin : g_chk_aempty
    $error("sync_fifo_ctrl: AEMPTY_THRESH must be in 0..DEPTH-1");
  end
  if (FWFT > 1) begin : g_chk_fwft
    $error("sync_fifo_ctrl: FWFT must be 0 or 1");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    wptr_q, wptr_d;
  logic [CW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             full_c, empty_c;
  logic             wr_acc_c, rd_acc_c;

  // Status flags decode the registered count only, so they never glitch on inputs.
  assign full_c   = (count_q == CW'(DEPTH));
  assign empty_c  = (count_q == CW'(0));
  assign wr_acc_c = bus.wen && !full_c;
  assign rd_acc_c = bus.ren && !empty_c;

  // Next-state for pointers, count and sticky error flags.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (wr_acc_c) wptr_d = wptr_q + CW'(1);
    if (rd_acc_c) rptr_d = rptr_q + CW'(1);
    // Pointers wrap modulo 2*DEPTH, so their difference is the occupancy.
    count_d = wptr_d - rptr_d;
    // A new error event wins over a same-cycle clear.
    ovf_d   = (bus.wen && full_c)  || (ovf_q && !bus.err_clr);
    udf_d   = (bus.ren && empty_c) || (udf_q && !bus.err_clr);
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage array; cleared on reset so show-ahead reads of an empty FIFO see 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_acc_c) begin
      mem_q[wptr_q[AW-1:0]] <= bus.wdata;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Show-ahead: head entry is presented directly from memory.
    assign bus.rdata  = mem_q[rptr_q[AW-1:0]];
    assign bus.rvalid = !empty_c;
  end else begin : g_reg_read
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    // Registered read: capture head on an accepted read, otherwise hold.
    always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      if (rd_acc_c) begin
        rdata_d  = mem_q[rptr_q[AW-1:0]];
        rvalid_d = 1'b1;
      end
    end

    // Read data output register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rdata_q  <= rdata_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
  end

  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.almost_full  = (count_q >= CW'(AFULL_THRESH));
  assign bus.almost_empty = (count_q <= CW'(AEMPTY_THRESH));
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Single-clock parametrised FIFO; next generation of the team's pointer-based FIFO for same-domain buffering.
- Adds almost-full and almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags.
- Selectable read mode: first-word-fall-through (show-ahead) or registered one-cycle read.
- Sits between producer and consumer stages in one clock domain; the thresholds provide early backpressure.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 8, number of entries; power of 2, >= 2
AFULL_THRESH, DEPTH-2, almost_full asserts when count >= this; legal range 1..DEPTH
AEMPTY_THRESH, 1, almost_empty asserts when count <= this; legal range 0..DEPTH-1
FWFT, 0, 1 = show-ahead read; 0 = registered read with 1-cycle latency

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; asynchronous, active-high
wdata  input  WIDTH  write data
wen  input  1  write request
full  output  1  count == DEPTH
almost_full  output  1  count >= AFULL_THRESH
ren  input  1  read request
rdata  output  WIDTH  read data
rvalid  output  1  FWFT=0: rdata updated this cycle; FWFT=1: equals !empty
empty  output  1  count == 0
almost_empty  output  1  count <= AEMPTY_THRESH
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  sticky; set by a write attempted while full
underflow  output  1  sticky; set by a read attempted while empty
err_clr  input  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (rst high, asynchronous, takes effect at any time including mid-operation):
  - wptr, rptr and count go to 0.
  - All memory entries go to 0.
  - rdata = 0, rvalid = 0, overflow = 0, underflow = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
- Pointers are $clog2(DEPTH)+1 bits, wrap modulo 2*DEPTH. The memory index is the low $clog2(DEPTH) bits.
- Accept rules: write accepted iff wen && !full; read accepted iff ren && !empty.
- full, empty, almost_full and almost_empty are combinational decodes of the registered count. They change on the cycle after the accepted access; there is no glitching from the inputs.
- Count update per clock edge:
  - +1 for write-only accepted.
  - -1 for read-only accepted.
  - Unchanged when both are accepted or neither is.
- Simultaneous access at boundaries:
  - Full + wen + ren: read accepted, write rejected, count -> DEPTH-1, overflow set.
  - Empty + wen + ren: write accepted, read rejected, count -> 1, underflow set.
- Accepted write: mem[wptr] <= wdata, wptr increments.
- Accepted read: rptr increments.
- FWFT=1:
  - rdata = mem[rptr] combinationally; rvalid = !empty.
  - Written data is visible one cycle after its write.
  - rdata is undefined for use while empty; it reads memory, which is 0 after reset.
- FWFT=0:
  - On an accepted read, rdata <= mem[rptr] and rvalid = 1 on the following cycle.
  - Otherwise rdata holds and rvalid = 0.
- Error flags:
  - overflow is set on a cycle with wen && full; underflow is set on a cycle with ren && empty.
  - Both hold until err_clr.
  - If err_clr and a new error event occur in the same cycle, set wins.
  - Rejected accesses never alter pointers, memory or count.
- Invariants:
  - count == wptr - rptr (mod 2*DEPTH), and count <= DEPTH.
  - full and empty are never both 1.
  - Data leaves in write order, with no loss or duplication.
- Elaboration: illegal parameter values (non-power-of-2 DEPTH, thresholds out of range) stop elaboration with an error.

Test Plan:
- DEPTH=8, FWFT=0, AFULL_THRESH=6, AEMPTY_THRESH=1; reset then write 0x01..0x08 -> count steps 1..8; almost_empty drops when count=2; almost_full rises when count=6; full=1 after the 8th write.
- From full, wen=1 ren=0 with wdata=0xAA -> count stays 8, memory unchanged, overflow=1; pulse err_clr -> overflow=0 next cycle.
- From full, wen=1 ren=1 -> count=7, full=0, overflow=1; rvalid=1 next cycle with rdata=0x01.
- Drain 7 reads -> rdata 0x02..0x08 in order, each with rvalid; empty=1 after the last; one extra ren -> underflow=1, rdata holds 0x08, rvalid=0.
- FWFT=1: write 0x5A into empty FIFO -> next cycle empty=0, rvalid=1, rdata=0x5A before any ren; 20 random interleaved ops across pointer wrap -> output order matches a reference queue.
- Count=5 mid-stream, assert rst between clock edges -> immediately count=0, empty=1, full=0, flags=0, rdata=0; after release, first write 0x33 reads back 0x33.
